tlb_tag_array: RTL and testbench

- Fully associative 16-entry Sv39 TLB tag store with tree-PLRU replacement.
- Writes and holds the tag state that core coverage samples; drives tags_o as a cov_core_defs::tlb_tags_q_t snapshot.
- Sits beside the ITLB/DTLB data arrays. The PTW is the update source, the MMU is the lookup source, and fence.vma is the flush source.

---
 rtl/cov_core_defs.sv | 25 ++
 rtl/plru_tree.sv | 58 +++++
 rtl/tlb_tag_array.sv | 133 +++++++++++++
 tb/tb_tlb_tag_array.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cov_core_defs.sv
// Shared core-coverage definitions: TLB tag layout and the snapshot type sampled by coverage.
package cov_core_defs;

    localparam int unsigned TLB_ENTRIES = 16;
    localparam int unsigned ASID_WIDTH  = 16;

    typedef struct packed {
        logic                  valid;
        logic [ASID_WIDTH-1:0] asid;
        logic [8:0]            vpn2;
        logic [8:0]            vpn1;
        logic [8:0]            vpn0;
        logic                  is_2M;
        logic                  is_1G;
    } tlb_tag_t;

    typedef tlb_tag_t [TLB_ENTRIES-1:0] tlb_tags_q_t;

    // Size-aware VPN compare: lower VPN fields are don't-care for super pages.
    function automatic logic vpn_match(tlb_tag_t t, logic [26:0] vpn);
        return (t.vpn2 == vpn[26:18]) &&
               (t.is_1G || ((t.vpn1 == vpn[17:9]) && (t.is_2M || (t.vpn0 == vpn[8:0]))));
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU state for ENTRIES ways; accepts up to two accesses per cycle (lookup, update).
module plru_tree #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       lu_valid_i,
    input  logic [$clog2(ENTRIES)-1:0] lu_idx_i,
    input  logic                       upd_valid_i,
    input  logic [$clog2(ENTRIES)-1:0] upd_idx_i,
    output logic [$clog2(ENTRIES)-1:0] victim_idx_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-2:0] tree_q, tree_d;

    // Heap-ordered nodes; each node on the path is pointed away from the accessed leaf.
    function automatic logic [ENTRIES-2:0] touch(logic [ENTRIES-2:0] tree, logic [IDX_W-1:0] idx);
        logic [ENTRIES-2:0] t;
        int unsigned        node;
        t = tree;
        for (int unsigned l = 0; l < IDX_W; l++) begin
            node    = (32'd1 << l) - 32'd1 + 32'(idx >> (IDX_W - l));
            t[node] = ~idx[IDX_W-1-l];
        end
        return t;
    endfunction

    always_comb begin
        tree_d = tree_q;
        if (lu_valid_i) begin
            tree_d = touch(tree_d, lu_idx_i);
        end
        if (upd_valid_i) begin
            tree_d = touch(tree_d, upd_idx_i);
        end
    end

    always_comb begin : victim_walk
        int unsigned node;
        node         = 0;
        victim_idx_o = '0;
        for (int unsigned l = 0; l < IDX_W; l++) begin
            victim_idx_o[IDX_W-1-l] = tree_q[node];
            node                    = 2 * node + 1 + 32'(tree_q[node]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tree_q <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

endmodule

// File: rtl/tlb_tag_array.sv
// Fully associative Sv39 TLB tag store: zero-latency lookup, PTW update, fence.vma flush, PLRU.
module tlb_tag_array
    import cov_core_defs::tlb_tag_t, cov_core_defs::tlb_tags_q_t, cov_core_defs::vpn_match;
#(
    parameter int unsigned TLB_ENTRIES = cov_core_defs::TLB_ENTRIES,
    parameter int unsigned ASID_W      = cov_core_defs::ASID_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic [ASID_W-1:0]              flush_asid_i,
    input  logic [26:0]                    flush_vpn_i,
    input  logic                           update_valid_i,
    input  logic [26:0]                    update_vpn_i,
    input  logic [ASID_W-1:0]              update_asid_i,
    input  logic                           update_is_2M_i,
    input  logic                           update_is_1G_i,
    input  logic                           lu_access_i,
    input  logic [ASID_W-1:0]              lu_asid_i,
    input  logic [26:0]                    lu_vpn_i,
    output logic                           lu_hit_o,
    output logic [$clog2(TLB_ENTRIES)-1:0] lu_hit_idx_o,
    output logic                           lu_is_2M_o,
    output logic                           lu_is_1G_o,
    output logic [$clog2(TLB_ENTRIES)-1:0] replace_idx_o,
    output tlb_tags_q_t                    tags_o
);

    localparam int unsigned IDX_W = $clog2(TLB_ENTRIES);

    tlb_tag_t [TLB_ENTRIES-1:0] tags_q, tags_d;
    tlb_tag_t                   new_tag;

    logic             lu_hit;
    logic [IDX_W-1:0] lu_idx;
    logic             upd_hit;
    logic [IDX_W-1:0] upd_hit_idx;
    logic             has_invalid;
    logic [IDX_W-1:0] inv_idx;
    logic [IDX_W-1:0] victim_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_fire;

    // Descending scans so the lowest matching index wins.
    always_comb begin
        lu_hit      = 1'b0;
        lu_idx      = '0;
        upd_hit     = 1'b0;
        upd_hit_idx = '0;
        has_invalid = 1'b0;
        inv_idx     = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (tags_q[i].valid && tags_q[i].asid == lu_asid_i &&
                vpn_match(tags_q[i], lu_vpn_i)) begin
                lu_hit = 1'b1;
                lu_idx = IDX_W'(i);
            end
            if (tags_q[i].valid && tags_q[i].asid == update_asid_i &&
                tags_q[i].is_2M == update_is_2M_i && tags_q[i].is_1G == update_is_1G_i &&
                vpn_match(tags_q[i], update_vpn_i)) begin
                upd_hit     = 1'b1;
                upd_hit_idx = IDX_W'(i);
            end
            if (!tags_q[i].valid) begin
                has_invalid = 1'b1;
                inv_idx     = IDX_W'(i);
            end
        end
    end

    assign lu_hit_o      = lu_access_i & lu_hit;
    assign lu_hit_idx_o  = lu_hit_o ? lu_idx : '0;
    assign lu_is_2M_o    = lu_hit_o & tags_q[lu_idx].is_2M;
    assign lu_is_1G_o    = lu_hit_o & tags_q[lu_idx].is_1G;

    assign replace_idx_o = has_invalid ? inv_idx : victim_idx;
    assign upd_idx       = upd_hit ? upd_hit_idx : replace_idx_o;
    assign upd_fire      = update_valid_i & ~flush_i;

    always_comb begin
        new_tag       = '0;
        new_tag.valid = 1'b1;
        new_tag.asid  = update_asid_i;
        new_tag.vpn2  = update_vpn_i[26:18];
        new_tag.vpn1  = update_vpn_i[17:9];
        new_tag.vpn0  = update_vpn_i[8:0];
        new_tag.is_2M = update_is_2M_i;
        new_tag.is_1G = update_is_1G_i;
    end

    // A zero ASID or zero VPN in the flush request acts as a wildcard.
    always_comb begin
        tags_d = tags_q;
        if (flush_i) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                if ((flush_asid_i == '0 || tags_q[i].asid == flush_asid_i) &&
                    (flush_vpn_i == '0 || vpn_match(tags_q[i], flush_vpn_i))) begin
                    tags_d[i].valid = 1'b0;
                end
            end
        end else if (update_valid_i) begin
            tags_d[upd_idx] = new_tag;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tags_q <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

    assign tags_o = tags_q;

    plru_tree #(
        .ENTRIES (TLB_ENTRIES)
    ) u_plru (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lu_valid_i   (lu_hit_o),
        .lu_idx_i     (lu_idx),
        .upd_valid_i  (upd_fire),
        .upd_idx_i    (upd_idx),
        .victim_idx_o (victim_idx)
    );

`ifndef SYNTHESIS
    size_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(update_valid_i && update_is_2M_i && update_is_1G_i));
`endif

endmodule

// File: tb/tb_tlb_tag_array.sv
// Directed scoreboard bench for tlb_tag_array: stimulus queues expectations, a monitor checks them.
module tb_tlb_tag_array;
    import cov_core_defs::*;

    localparam int K_HIT  = 0;
    localparam int K_REPL = 1;
    localparam int K_TAG  = 2;
    localparam int K_ZERO = 3;
    localparam int K_MASK = 4;

    typedef struct {
        int          kind;
        int          idx;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [15:0] flush_asid;
    logic [26:0] flush_vpn;
    logic        update_valid;
    logic [26:0] update_vpn;
    logic [15:0] update_asid;
    logic        update_is_2M;
    logic        update_is_1G;
    logic        lu_access;
    logic [15:0] lu_asid;
    logic [26:0] lu_vpn;
    logic        lu_hit;
    logic [3:0]  lu_hit_idx;
    logic        lu_is_2M;
    logic        lu_is_1G;
    logic [3:0]  replace_idx;
    tlb_tags_q_t tags;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tlb_tag_array dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .flush_asid_i   (flush_asid),
        .flush_vpn_i    (flush_vpn),
        .update_valid_i (update_valid),
        .update_vpn_i   (update_vpn),
        .update_asid_i  (update_asid),
        .update_is_2M_i (update_is_2M),
        .update_is_1G_i (update_is_1G),
        .lu_access_i    (lu_access),
        .lu_asid_i      (lu_asid),
        .lu_vpn_i       (lu_vpn),
        .lu_hit_o       (lu_hit),
        .lu_hit_idx_o   (lu_hit_idx),
        .lu_is_2M_o     (lu_is_2M),
        .lu_is_1G_o     (lu_is_1G),
        .replace_idx_o  (replace_idx),
        .tags_o         (tags)
    );

    function automatic logic [63:0] actual(int kind, int idx);
        logic [63:0] v;
        v = '0;
        case (kind)
            K_HIT:  v = 64'({lu_hit, lu_hit_idx, lu_is_2M, lu_is_1G});
            K_REPL: v = 64'(replace_idx);
            K_TAG:  v = 64'({tags[idx].valid, tags[idx].vpn2, tags[idx].vpn1, tags[idx].vpn0});
            K_ZERO: v = 64'(|tags);
            K_MASK: for (int i = 0; i < 16; i++) v[i] = tags[i].valid;
            default: v = '1;
        endcase
        return v;
    endfunction

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    initial begin
        exp_t        it;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                it  = sb.pop_front();
                act = actual(it.kind, it.idx);
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    function automatic logic [63:0] hcode(logic h, logic [3:0] idx, logic m2, logic g1);
        return 64'({h, idx, m2, g1});
    endfunction

    task automatic expect_(input int kind, input int idx, input logic [63:0] exp,
                           input string name);
        exp_t it;
        it.kind = kind;
        it.idx  = idx;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic clear_inputs();
        flush        = 1'b0;
        flush_asid   = '0;
        flush_vpn    = '0;
        update_valid = 1'b0;
        update_vpn   = '0;
        update_asid  = '0;
        update_is_2M = 1'b0;
        update_is_1G = 1'b0;
        lu_access    = 1'b0;
        lu_asid      = '0;
        lu_vpn       = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic upd(input logic [26:0] vpn, input logic [15:0] asid, input logic m2,
                       input logic g1);
        update_valid = 1'b1;
        update_vpn   = vpn;
        update_asid  = asid;
        update_is_2M = m2;
        update_is_1G = g1;
    endtask

    task automatic look(input logic [26:0] vpn, input logic [15:0] asid);
        lu_access = 1'b1;
        lu_vpn    = vpn;
        lu_asid   = asid;
    endtask

    task automatic fl(input logic [15:0] asid, input logic [26:0] vpn);
        flush      = 1'b1;
        flush_asid = asid;
        flush_vpn  = vpn;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12 rst_n = 1'b1;

        // Reset state
        cyc(); look(27'h0001234, 16'd1);
        expect_(K_HIT, 0, hcode(0, 0, 0, 0), "reset_lookup");
        expect_(K_REPL, 0, 64'd0, "reset_repl");
        expect_(K_ZERO, 0, 64'd0, "reset_tags");

        // 4K page
        cyc(); upd(27'h0001234, 16'd1, 0, 0);
        cyc(); look(27'h0001234, 16'd1);
        expect_(K_HIT, 0, hcode(1, 0, 0, 0), "hit_4k");
        expect_(K_REPL, 0, 64'd1, "repl_after_one");
        expect_(K_TAG, 0, 64'({1'b1, 27'h0001234}), "tag0_4k");
        cyc(); look(27'h0001235, 16'd1);
        expect_(K_HIT, 0, hcode(0, 0, 0, 0), "miss_4k");

        // 1G page, vpn2=5
        cyc(); upd({9'd5, 9'd0, 9'd0}, 16'd2, 0, 1);
        cyc(); look({9'd5, 9'h1AB, 9'h0CD}, 16'd2);
        expect_(K_HIT, 0, hcode(1, 1, 0, 1), "hit_1g");
        cyc(); look({9'd5, 9'h1AB, 9'h0CD}, 16'd3);
        expect_(K_HIT, 0, hcode(0, 0, 0, 0), "miss_1g_asid");

        // 2M page
        cyc(); upd({9'd1, 9'd2, 9'd3}, 16'd1, 1, 0);
        cyc(); look({9'd1, 9'd2, 9'd99}, 16'd1);
        expect_(K_HIT, 0, hcode(1, 2, 1, 0), "hit_2m");
        cyc(); look({9'd1, 9'd3, 9'd3}, 16'd1);
        expect_(K_HIT, 0, hcode(0, 0, 0, 0), "miss_2m");

        // Same tag again overwrites in place
        cyc(); upd(27'h0001234, 16'd1, 0, 0);
        cyc();
        expect_(K_MASK, 0, 64'h7, "dedup_mask");
        expect_(K_REPL, 0, 64'd3, "dedup_repl");

        // Clean slate, then fill all 16 entries (odd entries use ASID 2)
        cyc(); rst_n = 1'b0; #2 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(); upd(27'h100 + 27'(i), (i % 2 == 1) ? 16'd2 : 16'd1, 0, 0);
        end
        cyc(); look(27'h100, 16'd1);
        expect_(K_MASK, 0, 64'hFFFF, "fill_mask");
        expect_(K_REPL, 0, 64'd0, "fill_repl");
        expect_(K_HIT, 0, hcode(1, 0, 0, 0), "fill_hit0");
        cyc(); upd(27'h1FF, 16'd1, 0, 0);
        expect_(K_REPL, 0, 64'd8, "plru_victim");
        cyc(); look(27'h108, 16'd1);
        expect_(K_TAG, 8, 64'({1'b1, 27'h1FF}), "tag8_new");
        expect_(K_HIT, 0, hcode(0, 0, 0, 0), "evicted_8");
        expect_(K_MASK, 0, 64'hFFFF, "replace_mask");

        // Flush by ASID; the lookup in the flush cycle still sees old tags
        cyc(); fl(16'd2, 27'd0); look(27'h101, 16'd2);
        expect_(K_HIT, 0, hcode(1, 1, 0, 0), "flush_cycle_lookup");
        cyc();
        expect_(K_MASK, 0, 64'h5555, "flush_asid_mask");
        expect_(K_REPL, 0, 64'd1, "flush_asid_repl");
        cyc(); fl(16'd0, 27'h100);
        cyc();
        expect_(K_MASK, 0, 64'h5554, "flush_vpn_mask");
        expect_(K_REPL, 0, 64'd0, "flush_vpn_repl");
        cyc(); fl(16'd0, 27'd0);
        cyc();
        expect_(K_MASK, 0, 64'h0, "flush_all");

        // Flush wins over a simultaneous update
        cyc(); fl(16'd0, 27'd0); upd(27'h777, 16'd1, 0, 0);
        cyc(); look(27'h777, 16'd1);
        expect_(K_MASK, 0, 64'h0, "flush_wins_mask");
        expect_(K_HIT, 0, hcode(0, 0, 0, 0), "flush_wins_lookup");

        // Asynchronous reset during an update
        cyc(); upd(27'h777, 16'd1, 0, 0);
        cyc();
        expect_(K_TAG, 0, 64'({1'b1, 27'h777}), "tag0_777");
        cyc(); upd(27'h888, 16'd1, 0, 0); #1 rst_n = 1'b0;
        expect_(K_ZERO, 0, 64'd0, "async_reset_tags");
        expect_(K_REPL, 0, 64'd0, "async_reset_repl");
        cyc(); rst_n = 1'b1;
        expect_(K_MASK, 0, 64'h0, "after_reset_mask");

        repeat (2) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
